// File: rtl/analyse_data.sv
// Answer-frame receiver: slices ADC against mean_def + THRESH, frames 36-bit
// Manchester answers. Optional macro ANALYSE_DATA_ECHO_CHECK_EN gates ready on mode/type echo.
module analyse_data #(
    parameter int unsigned BIT_PERIOD = 200000,
    parameter logic [11:0] THRESH     = 12'd50
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        swiptAlive_i,
    input  logic [1:0]  program_i,
    input  logic        readDataIn_i,
    input  logic [11:0] ADC_i,
    input  logic [11:0] mean_def_i,
    input  logic [1:0]  mode_i,
    input  logic [1:0]  type_i,
    output logic        din_o,
    output logic        dataInReady_o,
    output logic [7:0]  dataIn_o,
    output logic [7:0]  sumChecker_o,
    output logic        checkSumBit_o
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] CHECK  = 2'd3;

    localparam logic [5:0] PREAMBLE = 6'b101010;
    localparam logic [3:0] TAIL     = 4'b0101;

    // Half-period lands the first sample mid-bit; clamp so tiny periods never underflow.
    localparam int unsigned HALF    = BIT_PERIOD / 2;
    localparam logic [23:0] HALF_M1 = (HALF > 0) ? 24'(HALF - 1) : 24'd0;
    localparam logic [23:0] PER_M1  = (BIT_PERIOD > 0) ? 24'(BIT_PERIOD - 1) : 24'd0;

    logic        din_q, din_prev_q;
    logic [1:0]  state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic [35:0] sr_q, sr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  sum_q, sum_d;
    logic        cs_q, cs_d;
    logic        rdy_q, rdy_d;

    logic        active;
    logic        slice;
    logic [7:0]  d_w;
    logic [7:0]  pv_w;
    logic        par_ok;
    logic        pre_ok;
    logic        tail_ok;
    logic        echo_ok;

    assign active = nrst & swiptAlive_i & (program_i == 2'b11) & readDataIn_i;

    assign slice = {1'b0, ADC_i} > ({1'b0, mean_def_i} + {1'b0, THRESH});

    // Data bits and pair validity: frame bit 0 sits at sr_q[35], d_i pair at sr_q[7+2i:6+2i].
    always_comb begin
        d_w  = '0;
        pv_w = '0;
        for (int i = 0; i < 8; i++) begin
            d_w[i]  = sr_q[6 + 2*i];
            pv_w[i] = sr_q[7 + 2*i] ^ sr_q[6 + 2*i];
        end
    end

    assign par_ok  = (sr_q[5] == ~^d_w) && (sr_q[4] == ^d_w);
    assign pre_ok  = sr_q[35:30] == PREAMBLE;
    assign tail_ok = sr_q[3:0] == TAIL;

`ifdef ANALYSE_DATA_ECHO_CHECK_EN
    assign echo_ok = (sr_q[29] ^ sr_q[28]) && (sr_q[27] ^ sr_q[26])
                  && (sr_q[25] ^ sr_q[24]) && (sr_q[23] ^ sr_q[22])
                  && ({sr_q[28], sr_q[26]} == mode_i)
                  && ({sr_q[24], sr_q[22]} == type_i);
`else
    logic unused_echo;
    assign unused_echo = ^{mode_i, type_i};
    assign echo_ok = 1'b1;
`endif

    // Framer next-state: hunt for a rising edge, centre on it, shift in 36 bits, judge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        sr_d     = sr_q;
        data_d   = data_q;
        sum_d    = sum_q;
        cs_d     = cs_q;
        rdy_d    = 1'b0;
        if (!active) begin
            state_d  = HUNT;
            cnt_d    = '0;
            bitcnt_d = '0;
            sr_d     = '0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    if (din_q && !din_prev_q) begin
                        state_d  = SYNC;
                        cnt_d    = '0;
                        bitcnt_d = '0;
                        sr_d     = '0;
                    end
                end
                SYNC: begin
                    if (cnt_q == HALF_M1) begin
                        sr_d     = {sr_q[34:0], din_q};
                        bitcnt_d = 6'd1;
                        cnt_d    = '0;
                        state_d  = SAMPLE;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                SAMPLE: begin
                    if (bitcnt_q == 6'd6 && sr_q[5:0] != PREAMBLE) begin
                        state_d  = HUNT;
                        cnt_d    = '0;
                        bitcnt_d = '0;
                    end else if (cnt_q == PER_M1) begin
                        sr_d     = {sr_q[34:0], din_q};
                        bitcnt_d = bitcnt_q + 6'd1;
                        cnt_d    = '0;
                        if (bitcnt_q == 6'd35) begin
                            state_d = CHECK;
                        end
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                CHECK: begin
                    if (tail_ok) begin
                        data_d = d_w;
                        sum_d  = pv_w;
                        cs_d   = par_ok;
                    end
                    rdy_d    = tail_ok && pre_ok && (&pv_w) && echo_ok;
                    state_d  = HUNT;
                    cnt_d    = '0;
                    bitcnt_d = '0;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            din_q      <= 1'b0;
            din_prev_q <= 1'b0;
            state_q    <= HUNT;
            cnt_q      <= '0;
            bitcnt_q   <= '0;
            sr_q       <= '0;
            data_q     <= '0;
            sum_q      <= '0;
            cs_q       <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            din_q      <= slice;
            din_prev_q <= din_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitcnt_q   <= bitcnt_d;
            sr_q       <= sr_d;
            data_q     <= data_d;
            sum_q      <= sum_d;
            cs_q       <= cs_d;
            rdy_q      <= rdy_d;
        end
    end

    assign din_o         = din_q;
    assign dataInReady_o = rdy_q;
    assign dataIn_o      = data_q;
    assign sumChecker_o  = sum_q;
    assign checkSumBit_o = cs_q;

endmodule

// File: tb/tb_analyse_data.sv
// Directed bench for analyse_data: slicing, framing, parity, pair errors,
// preamble rejection, abort mid-frame and echo field handling.
module tb_analyse_data;

    localparam int BP = 8;
    localparam logic [11:0] HI = 12'd1200;
    localparam logic [11:0] LO = 12'd1000;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        swiptAlive = 1'b1;
    logic [1:0]  prog = 2'b11;
    logic        readDataIn = 1'b0;
    logic [11:0] ADC = LO;
    logic [11:0] mean_def = 12'd1000;
    logic [1:0]  mode = 2'd2;
    logic [1:0]  typ = 2'd1;
    logic        din;
    logic        dataInReady;
    logic [7:0]  dataIn;
    logic [7:0]  sumChecker;
    logic        checkSumBit;

    int passed = 0;
    int total = 0;
    int pulses = 0;
    int p0;

    analyse_data #(.BIT_PERIOD(BP), .THRESH(12'd50)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .swiptAlive_i  (swiptAlive),
        .program_i     (prog),
        .readDataIn_i  (readDataIn),
        .ADC_i         (ADC),
        .mean_def_i    (mean_def),
        .mode_i        (mode),
        .type_i        (typ),
        .din_o         (din),
        .dataInReady_o (dataInReady),
        .dataIn_o      (dataIn),
        .sumChecker_o  (sumChecker),
        .checkSumBit_o (checkSumBit)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dataInReady === 1'b1) pulses <= pulses + 1;
    end

    function automatic logic [35:0] mk(input logic [1:0] m, input logic [1:0] t,
                                       input logic [7:0] d, input logic pinv);
        logic [15:0] dp;
        logic        p;
        for (int i = 0; i < 8; i++) begin
            dp[2*i+1] = ~d[i];
            dp[2*i]   = d[i];
        end
        p = ^d ^ pinv;
        return {6'b101010, ~m[1], m[1], ~m[0], m[0],
                ~t[1], t[1], ~t[0], t[0], dp, ~p, p, 4'b0101};
    endfunction

    task automatic send_bits(input logic [35:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ADC = f[35-i] ? HI : LO;
            repeat (BP) @(negedge clk);
        end
        ADC = LO;
    endtask

    task automatic send_frame(input logic [35:0] f);
        ADC = LO;
        repeat (2*BP) @(negedge clk);
        p0 = pulses;
        send_bits(f, 36);
        repeat (3*BP) @(negedge clk);
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        readDataIn = 1'b1;
        ADC = HI;
        repeat (3) @(negedge clk);
        total++; if (din !== 1'b0) $display("FAIL rst_din got %b want 0", din); else passed++;
        total++; if (dataInReady !== 1'b0) $display("FAIL rst_rdy got %b want 0", dataInReady); else passed++;
        total++; if (dataIn !== 8'h00) $display("FAIL rst_data got %h want 00", dataIn); else passed++;
        total++; if (sumChecker !== 8'h00) $display("FAIL rst_sum got %h want 00", sumChecker); else passed++;
        total++; if (checkSumBit !== 1'b0) $display("FAIL rst_cs got %b want 0", checkSumBit); else passed++;
        total++; if (dut.state_q !== 2'd0) $display("FAIL rst_state got %0d want 0", dut.state_q); else passed++;
        readDataIn = 1'b0;
        ADC = LO;
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_din_thresh;
        ADC = 12'd1050; @(negedge clk); @(negedge clk);
        total++; if (din !== 1'b0) $display("FAIL din_1050 got %b want 0", din); else passed++;
        ADC = 12'd1051; @(negedge clk); @(negedge clk);
        total++; if (din !== 1'b1) $display("FAIL din_1051 got %b want 1", din); else passed++;
        mean_def = 12'd4095; ADC = 12'd4095; @(negedge clk); @(negedge clk);
        total++; if (din !== 1'b0) $display("FAIL din_nowrap got %b want 0", din); else passed++;
        mean_def = 12'd4000; @(negedge clk); @(negedge clk);
        total++; if (din !== 1'b1) $display("FAIL din_hi got %b want 1", din); else passed++;
        mean_def = 12'd1000; ADC = LO;
        repeat (2) @(negedge clk);
        readDataIn = 1'b1;
    endtask

    task automatic test_valid;
        send_frame(mk(2'd2, 2'd1, 8'hA5, 1'b0));
        total++; if (pulses - p0 !== 1) $display("FAIL valid_pulse got %0d want 1", pulses - p0); else passed++;
        total++; if (dataIn !== 8'hA5) $display("FAIL valid_data got %h want a5", dataIn); else passed++;
        total++; if (sumChecker !== 8'hFF) $display("FAIL valid_sum got %h want ff", sumChecker); else passed++;
        total++; if (checkSumBit !== 1'b1) $display("FAIL valid_cs got %b want 1", checkSumBit); else passed++;
    endtask

    task automatic test_parity;
        send_frame(mk(2'd2, 2'd1, 8'hA5, 1'b1));
        total++; if (pulses - p0 !== 1) $display("FAIL par_pulse got %0d want 1", pulses - p0); else passed++;
        total++; if (dataIn !== 8'hA5) $display("FAIL par_data got %h want a5", dataIn); else passed++;
        total++; if (checkSumBit !== 1'b0) $display("FAIL par_cs got %b want 0", checkSumBit); else passed++;
    endtask

    task automatic test_bad_pair;
        logic [35:0] f;
        f = mk(2'd2, 2'd1, 8'hA5, 1'b0);
        f[13:12] = 2'b11;
        send_frame(f);
        total++; if (pulses - p0 !== 0) $display("FAIL pair_pulse got %0d want 0", pulses - p0); else passed++;
        total++; if (dataIn !== 8'hAD) $display("FAIL pair_data got %h want ad", dataIn); else passed++;
        total++; if (sumChecker !== 8'hF7) $display("FAIL pair_sum got %h want f7", sumChecker); else passed++;
        total++; if (checkSumBit !== 1'b0) $display("FAIL pair_cs got %b want 0", checkSumBit); else passed++;
    endtask

    task automatic test_preamble;
        repeat (2*BP) @(negedge clk);
        p0 = pulses;
        send_bits({6'b101110, 30'd0}, 6);
        repeat (2*BP) @(negedge clk);
        total++; if (dut.state_q !== 2'd0) $display("FAIL pre_state got %0d want 0", dut.state_q); else passed++;
        total++; if (pulses - p0 !== 0) $display("FAIL pre_pulse got %0d want 0", pulses - p0); else passed++;
        total++; if (dataIn !== 8'hAD) $display("FAIL pre_data got %h want ad", dataIn); else passed++;
        total++; if (sumChecker !== 8'hF7) $display("FAIL pre_sum got %h want f7", sumChecker); else passed++;
    endtask

    task automatic test_drop;
        int q0;
        repeat (2*BP) @(negedge clk);
        q0 = pulses;
        send_bits(mk(2'd2, 2'd1, 8'h5A, 1'b0), 20);
        readDataIn = 1'b0;
        repeat (2*BP) @(negedge clk);
        total++; if (dut.state_q !== 2'd0) $display("FAIL drop_state got %0d want 0", dut.state_q); else passed++;
        readDataIn = 1'b1;
        send_frame(mk(2'd2, 2'd1, 8'h3C, 1'b0));
        total++; if (pulses - q0 !== 1) $display("FAIL drop_pulse got %0d want 1", pulses - q0); else passed++;
        total++; if (dataIn !== 8'h3C) $display("FAIL drop_data got %h want 3c", dataIn); else passed++;
    endtask

    task automatic test_echo;
        int exp_p;
`ifdef ANALYSE_DATA_ECHO_CHECK_EN
        exp_p = 0;
`else
        exp_p = 1;
`endif
        send_frame(mk(2'd2, 2'd2, 8'hC3, 1'b0));
        total++; if (pulses - p0 !== exp_p) $display("FAIL echo_pulse got %0d want %0d", pulses - p0, exp_p); else passed++;
        total++; if (dataIn !== 8'hC3) $display("FAIL echo_data got %h want c3", dataIn); else passed++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_din_thresh();
        test_valid();
        test_parity();
        test_bad_pair();
        test_preamble();
        test_drop();
        test_echo();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/analyse_data.md
ANALYSE_DATA -- requirements
Module: analyse_data

Interface
REQ-001 Parameter BIT_PERIOD, default 200000; clk cycles per received bit (matches transmit bit time).
REQ-002 Parameter THRESH, default 12'd50; ADC margin above mean_def that decodes a bit as 1.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 nrst  input  1  reset; synchronous, active-low.
REQ-005 swiptAlive  input  1  link alive; 0 aborts reception.
REQ-006 program  input  2  operating program; reception only when 2'b11.
REQ-007 readDataIn  input  1  receive window enable from controller.
REQ-008 ADC  input  12  raw receive-coil current sample.
REQ-009 mean_def  input  12  mean (idle) current level used as slicing reference.
REQ-010 mode, type  input  2 each  mode/type of the outstanding command, for echo check.
REQ-011 din  output  1  registered sliced bit.
REQ-012 dataInReady  output  1  one-cycle pulse, valid answer frame received.
REQ-013 dataIn  output  8  decoded answer byte.
REQ-014 sumChecker  output  8  per-bit Manchester validity of dataIn (bit i=1: pair i valid).
REQ-015 checkSumBit  output  1  1 when received parity pair matches parity of dataIn.

Function
REQ-016 din SHALL be registered each cycle as 1 when ADC > mean_def + THRESH (13-bit unsigned compare, no wrap), else 0.
REQ-017 Receiver active SHALL be nrst & swiptAlive & (program==2'b11) & readDataIn; while inactive the framer SHALL sit in HUNT and dataInReady SHALL be 0.
REQ-018 Answer frame SHALL be 36 bits, first bit first: preamble 101010; pairs (~m1,m1,~m0,m0,~t1,t1,~t0,t0); 8 data pairs (~d,d), d7 first; parity pair (~^d, ^d); tail 0101.
REQ-019 States: HUNT, SYNC, SAMPLE, CHECK.
REQ-020 HUNT -> SYNC on din rising edge (0 then 1) while active.
REQ-021 SYNC SHALL wait BIT_PERIOD/2 cycles, sample din as bit 0, then go SAMPLE.
REQ-022 SAMPLE SHALL sample din every BIT_PERIOD cycles into a 36-bit shift register until 36 bits held, then go CHECK.
REQ-023 After 6 bits, if preamble != 101010 the framer SHALL return to HUNT without updating outputs.
REQ-024 CHECK (one cycle): if tail == 0101, SHALL load dataIn with d bits, sumChecker with pair-valid flags (pair valid when its two bits differ), checkSumBit with parity-pair match; else outputs unchanged.
REQ-025 dataInReady SHALL pulse in the cycle after CHECK only if preamble and tail ok and sumChecker==8'hFF (plus echo check per REQ-031); framer then returns to HUNT.
REQ-026 Invalid data pair: d bit SHALL take the second bit of the pair.
REQ-027 Deasserting any active term mid-frame SHALL discard the partial frame and return to HUNT next cycle; dataIn/sumChecker/checkSumBit retained.
REQ-028 Bit counter and period counter SHALL be wide enough for BIT_PERIOD up to 2^24-1; no wrap.

Reset
REQ-029 On nrst=0 at clk edge: din=0, dataInReady=0, dataIn=0, sumChecker=0, checkSumBit=0, state HUNT, counters and shift register cleared.
REQ-030 Reset SHALL take priority over all other conditions.

Configuration
REQ-031 Macro ANALYSE_DATA_ECHO_CHECK_EN defined: dataInReady additionally requires echoed mode/type pairs valid and equal to mode/type inputs; undefined: echo field ignored, behaviour otherwise identical.

Verification (BIT_PERIOD=8, THRESH=50, mean_def=1000; bit 1 = ADC 1200, bit 0 = ADC 1000)
REQ-032 Valid frame, mode=2, type=1, d=8'hA5, parity ok -> dataInReady one pulse, dataIn=A5, sumChecker=FF, checkSumBit=1.
REQ-033 Same frame with parity pair inverted -> dataIn=A5, checkSumBit=0, dataInReady still pulses.
REQ-034 Data pair 3 sent as 11 -> sumChecker=F7, dataIn bit3=1, no dataInReady.
REQ-035 Preamble 101110 -> framer back in HUNT after bit 6, outputs unchanged, no pulse.
REQ-036 readDataIn dropped at bit 20, then full valid frame d=3C -> only second frame pulses, dataIn=3C.
REQ-037 With ANALYSE_DATA_ECHO_CHECK_EN, echo type=2 vs input type=1 -> no dataInReady; without macro -> pulse; ADC=1050 -> din=0, ADC=1051 -> din=1.
